// File: rtl/pc_sequencer.sv
// Program counter with next-PC selection, a circular return-address stack and
// an exception PC register; drives the instruction-fetch address.
module pc_sequencer #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] TRAP_VEC  = 'h100,
  parameter int unsigned      INC       = 4,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [2:0]                     pc_op,
  input  logic [WIDTH-1:0]               offset,
  input  logic [WIDTH-1:0]               target,
  input  logic                           trap,
  output logic [WIDTH-1:0]               pc,
  output logic [WIDTH-1:0]               pc_plus,
  output logic [WIDTH-1:0]               epc,
  output logic [$clog2(RAS_DEPTH):0]     ras_count,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);

  localparam int unsigned      PW    = $clog2(RAS_DEPTH);
  localparam int unsigned      CW    = PW + 1;
  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  typedef enum logic [2:0] {
    OP_SEQ    = 3'd0,
    OP_BRANCH = 3'd1,
    OP_JUMP   = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4,
    OP_TRET   = 3'd5
  } pc_op_e;

  pc_op_e           op;
  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]    ras_ptr;
  logic             ras_full;
  logic             ras_empty;
  logic             advance;

  assign op        = pc_op_e'(pc_op);
  assign pc_plus   = pc + INC_W;
  assign ras_full  = (ras_count == CW'(RAS_DEPTH));
  assign ras_empty = (ras_count == '0);
  assign advance   = enable && !trap;

  // Storage has no reset; only the pointer and count define which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && advance && op == OP_CALL) begin
      ras[ras_ptr + PW'(1)] <= pc_plus;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_VEC;
      epc           <= '0;
      ras_ptr       <= '0;
      ras_count     <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
      if (trap) begin
        epc <= pc;
        pc  <= TRAP_VEC;
      end else if (enable) begin
        case (op)
          OP_BRANCH: pc <= pc + offset;
          OP_JUMP:   pc <= target;
          OP_CALL: begin
            pc      <= target;
            ras_ptr <= ras_ptr + PW'(1);
            // A full stack silently drops its oldest entry as the pointer wraps onto it.
            if (ras_full) ras_overflow <= 1'b1;
            else          ras_count    <= ras_count + CW'(1);
          end
          OP_RET: begin
            if (!ras_empty) begin
              pc        <= ras[ras_ptr];
              ras_ptr   <= ras_ptr - PW'(1);
              ras_count <= ras_count - CW'(1);
            end else begin
              pc            <= pc_plus;
              ras_underflow <= 1'b1;
            end
          end
          OP_TRET:   pc <= epc;
          default:   pc <= pc_plus;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed walk through the documented scenarios, then
// random traffic, all compared every cycle against a queue-based reference.
module tb_pc_sequencer;

  localparam int W = 32;
  localparam int D = 4;
  localparam logic [2:0] SEQ = 3'd0, BRANCH = 3'd1, JUMP = 3'd2, CALL = 3'd3,
                         RET = 3'd4, TRET = 3'd5;

  logic         clk = 1'b0;
  logic         reset, enable, trap;
  logic [2:0]   pc_op;
  logic [W-1:0] offset, target;
  logic [W-1:0] pc, pc_plus, epc;
  logic [2:0]   ras_count;
  logic         ras_overflow, ras_underflow;

  pc_sequencer #(
    .WIDTH(W), .RESET_VEC(32'h0), .TRAP_VEC(32'h100), .INC(4), .RAS_DEPTH(D)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .pc_op(pc_op), .offset(offset),
    .target(target), .trap(trap), .pc(pc), .pc_plus(pc_plus), .epc(epc),
    .ras_count(ras_count), .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  // reference model: the RAS is a bounded queue, newest entry at the back
  logic [W-1:0] m_pc, m_epc;
  logic [W-1:0] m_ras[$];
  logic         m_ovf, m_unf;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 32'h0; m_epc = 32'h0; m_ras.delete(); m_ovf = 0; m_unf = 0;
    end else begin
      m_ovf = 0; m_unf = 0;
      if (trap) begin
        m_epc = m_pc;
        m_pc  = 32'h100;
      end else if (enable) begin
        case (pc_op)
          BRANCH: m_pc = m_pc + offset;
          JUMP:   m_pc = target;
          CALL: begin
            m_ovf = (m_ras.size() == D);
            m_ras.push_back(m_pc + 4);
            if (m_ras.size() > D) void'(m_ras.pop_front());
            m_pc = target;
          end
          RET: begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else begin m_pc = m_pc + 4; m_unf = 1; end
          end
          TRET:   m_pc = m_epc;
          default: m_pc = m_pc + 4;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare on the falling edge
  always @(negedge clk) begin
    if (check_en) begin
      chk("pc", pc, m_pc);
      chk("pc_plus", pc_plus, m_pc + 32'd4);
      chk("epc", epc, m_epc);
      chk("ras_count", W'(ras_count), W'(m_ras.size()));
      chk("ras_overflow", W'(ras_overflow), W'(m_ovf));
      chk("ras_underflow", W'(ras_underflow), W'(m_unf));
    end
  end

  // driver: apply inputs after a falling edge, return after the next falling edge
  task automatic step(input logic [2:0] op, input logic [W-1:0] off = '0,
                      input logic [W-1:0] tgt = '0, input logic en = 1'b1,
                      input logic tr = 1'b0, input logic rst = 1'b0);
    pc_op = op; offset = off; target = tgt; enable = en; trap = tr; reset = rst;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; trap = 1'b0; pc_op = SEQ; offset = '0; target = '0;
    @(negedge clk);
    step(SEQ, 0, 0, 1, 0, 1);
    check_en = 1'b1;
    chk("lit reset pc", pc, 32'h0);
    chk("lit reset epc", epc, 32'h0);
    chk("lit reset cnt", W'(ras_count), 32'd0);

    step(SEQ); step(SEQ); step(SEQ);
    chk("lit seq pc", pc, 32'hC);
    chk("lit seq pc_plus", pc_plus, 32'h10);
    step(SEQ, 0, 0, 0); step(CALL, 0, 32'h999, 0);
    chk("lit stall pc", pc, 32'hC);

    step(JUMP, 0, 32'h20);
    step(BRANCH, -32'sd8);
    chk("lit branch back", pc, 32'h18);
    step(JUMP, 0, 32'hFFFF_FFFC);
    chk("lit jump", pc, 32'hFFFF_FFFC);
    step(SEQ);
    chk("lit wrap", pc, 32'h0);

    step(JUMP, 0, 32'h40);
    step(CALL, 0, 32'h200);
    chk("lit call pc", pc, 32'h200);
    chk("lit call cnt", W'(ras_count), 32'd1);
    step(CALL, 0, 32'h300);
    chk("lit call2 cnt", W'(ras_count), 32'd2);
    step(RET);
    chk("lit ret1", pc, 32'h204);
    step(RET);
    chk("lit ret2", pc, 32'h44);
    step(RET);
    chk("lit ret empty pc", pc, 32'h48);
    chk("lit underflow", W'(ras_underflow), 32'd1);
    step(SEQ);
    chk("lit underflow drop", W'(ras_underflow), 32'd0);

    step(JUMP, 0, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      step(CALL, 0, W'(i * 16));
      if (i == 4) chk("lit no ovf yet", W'(ras_overflow), 32'd0);
    end
    chk("lit overflow", W'(ras_overflow), 32'd1);
    chk("lit ovf cnt", W'(ras_count), 32'd4);
    step(RET); chk("lit lifo 0", pc, 32'h44);
    chk("lit ovf drop", W'(ras_overflow), 32'd0);
    step(RET); chk("lit lifo 1", pc, 32'h34);
    step(RET); chk("lit lifo 2", pc, 32'h24);
    step(RET); chk("lit lifo 3", pc, 32'h14);
    chk("lit lifo cnt", W'(ras_count), 32'd0);

    step(JUMP, 0, 32'h58);
    step(CALL, 0, 32'h700, 0, 1);
    chk("lit trap pc", pc, 32'h100);
    chk("lit trap epc", epc, 32'h58);
    chk("lit trap cnt", W'(ras_count), 32'd0);
    step(SEQ);
    chk("lit trap seq", pc, 32'h104);
    step(TRET);
    chk("lit tret", pc, 32'h58);

    step(JUMP, 0, 32'h80);
    step(CALL, 0, 32'h500, 1, 1, 1);
    chk("lit rst pc", pc, 32'h0);
    chk("lit rst epc", epc, 32'h0);
    chk("lit rst cnt", W'(ras_count), 32'd0);
    chk("lit rst pulses", W'({ras_overflow, ras_underflow}), 32'd0);

    // random traffic, biased toward call/return so the stack fills and drains
    for (int i = 0; i < 1500; i++) begin
      logic [2:0] op;
      int r;
      r = $urandom_range(0, 99);
      op = (r < 30) ? CALL : (r < 60) ? RET : 3'($urandom_range(0, 7));
      step(op, W'($urandom_range(0, 255)) - 32'd128, W'($urandom) & 32'hFFFF_FFFC,
           $urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 199) == 0);
    end

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised successor to the basic program counter register.
- Holds the architectural PC and computes the next PC from a registered op: sequential, PC-relative branch, absolute jump, call/return, trap entry and trap return.
- Contains a circular return-address stack (RAS) and an exception PC (EPC) register.
- Sits at the head of the fetch stage and drives the instruction-memory address.

Parameters:
WIDTH, 32, PC/address width in bits
RESET_VEC, 0, PC value loaded on reset
TRAP_VEC, 32'h00000100, PC loaded on trap entry
INC, 4, byte increment for sequential flow
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  1 = advance PC this cycle; 0 = stall (hold all state)
pc_op  in  3  0 SEQ, 1 BRANCH, 2 JUMP, 3 CALL, 4 RET, 5 TRET, 6/7 reserved
offset  in  WIDTH  signed byte offset for BRANCH
target  in  WIDTH  absolute target for JUMP/CALL
trap  in  1  trap request
pc  out  WIDTH  current PC (registered)
pc_plus  out  WIDTH  pc + INC (combinational)
epc  out  WIDTH  saved exception PC (registered)
ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
ras_overflow  out  1  one-cycle pulse: push onto a full RAS
ras_underflow  out  1  one-cycle pulse: RET on an empty RAS

Behaviour:
- Reset (sampled on clk edge, highest priority):
  - pc=RESET_VEC, epc=0, ras_count=0, RAS pointer=0, both pulses 0.
  - RAS contents are don't-care after reset.
- Priority per edge: reset > trap > (enable=0 hold) > pc_op.
- trap=1:
  - Sets epc <= pc and pc <= TRAP_VEC.
  - Overrides enable=0 and pc_op.
  - RAS unchanged.
- enable=0, no trap: pc, epc, RAS and ras_count hold; pulses are 0.
- enable=1, no trap, next PC by pc_op:
  - SEQ: pc <= pc+INC.
  - BRANCH: pc <= pc+offset.
  - JUMP: pc <= target.
  - CALL: push pc+INC onto RAS; pc <= target.
  - RET, RAS non-empty: pc <= top entry; pop.
  - RET, RAS empty: pc <= pc+INC; ras_underflow=1 for one cycle; ras_count stays 0.
  - TRET: pc <= epc.
  - 6/7: behave as SEQ.
- Arithmetic: all adds are modulo 2^WIDTH (wrap, no flag). offset is two's complement at full WIDTH.
- RAS organisation:
  - Circular buffer with a top pointer.
  - Push writes at pointer+1 and advances the pointer (mod RAS_DEPTH).
  - Pop reads at the pointer and decrements it.
  - ras_count saturates at RAS_DEPTH.
- RAS full on push:
  - Oldest entry is overwritten; ras_count stays RAS_DEPTH.
  - ras_overflow=1 for one cycle.
  - A following RAS_DEPTH pops return the newest RAS_DEPTH addresses in LIFO order.
- Pulses: ras_overflow and ras_underflow are registered, high exactly the cycle after the causing edge. They are cleared by reset and by any edge without the cause.
- Latency: one cycle; pc reflects the op sampled at the previous edge. pc_plus follows pc combinationally.
- Reset asserted mid-sequence (e.g. with a pending CALL): reset wins; no push occurs.

Test Plan:
(Parameters: WIDTH=32, RESET_VEC=0, INC=4, TRAP_VEC=0x100, RAS_DEPTH=4.)
- Reset, then 3 edges of SEQ with enable=1 -> pc 0x0, 0x4, 0x8, 0xC; pc_plus=0x10. Drop enable for 2 edges -> pc holds 0xC.
- From pc=0x20, BRANCH offset=-8 -> pc=0x18. JUMP target=0xFFFFFFFC, then SEQ -> pc=0xFFFFFFFC then 0x0 (wrap).
- Call/return at pc=0x40:
  - CALL target=0x200 -> pc=0x200, ras_count=1.
  - CALL target=0x300 -> ras_count=2.
  - RET -> pc=0x204; RET -> pc=0x44.
  - RET on empty -> pc=0x48, ras_underflow high one cycle.
- Overflow:
  - 5 CALLs from pcs 0x0, 0x10, 0x20, 0x30, 0x40 (targets chosen accordingly) -> ras_overflow pulses on the 5th; ras_count=4.
  - 4 RETs -> 0x44, 0x34, 0x24, 0x14; ras_count=0.
- Trap and trap return:
  - Trap at pc=0x58 with enable=0 and pc_op=CALL -> pc=0x100, epc=0x58, ras_count unchanged.
  - SEQ -> 0x104; TRET -> pc=0x58.
- Reset asserted concurrently with trap and CALL at pc=0x80 -> pc=0x0, epc=0, ras_count=0, no pulses next cycle.
